// File: rtl/heichips25_spi_cfg_responder_if.sv
// Pad-side SPI pins and bitstream word sink of the configuration responder.
interface heichips25_spi_cfg_responder_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic              sclk_i;
  logic              cs_n_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_en_o;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;

  modport master (
    output sclk_i, cs_n_i, mosi_i, word_ready_i,
    input  miso_o, miso_en_o, word_o, word_valid_o
  );

  modport slave (
    input  sclk_i, cs_n_i, mosi_i, word_ready_i,
    output miso_o, miso_en_o, word_o, word_valid_o
  );
endinterface

// File: rtl/heichips25_spi_cfg_responder.sv
// SPI mode-0 responder that oversamples the pads in clk_i, packs WRITE frames into
// configuration words through a 2-entry FIFO and returns a status byte on STATUS frames.
module heichips25_spi_cfg_responder #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic busy_i,
  input  logic configured_i,
  heichips25_spi_cfg_responder_if.slave bus,
  output logic overrun_o,
  output logic frame_active_o
);
  localparam int unsigned NB = WORD_W / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_STATUS, ST_IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;
  assign frame_active_o = ~cs_s & en_i;

  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       byte_done;

  always_ff @(posedge clk_i) begin
    if (rst_i || cs_s) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (sclk_rise) begin
        shreg     <= {shreg[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
    end
  end

  state_t            state, state_d;
  logic [WORD_W-1:0] acc, acc_d;
  logic [BW-1:0]     idx, idx_d;
  logic              miso_q, miso_d;
  logic [7:0]        st_sh, st_sh_d;
  logic [7:0]        status;
  logic [WORD_W+7:0] shifted;
  logic              push_req, clr_ovr, do_push, do_pop, fifo_full;
  logic [WORD_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;

  assign shifted = {acc, shreg};
  assign status  = {busy_i, configured_i, overrun_o, fifo_full, 4'b0000};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      acc    <= '0;
      idx    <= '0;
      miso_q <= 1'b0;
      st_sh  <= '0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      idx    <= idx_d;
      miso_q <= miso_d;
      st_sh  <= st_sh_d;
    end
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    idx_d    = idx;
    miso_d   = miso_q;
    st_sh_d  = st_sh;
    push_req = 1'b0;
    clr_ovr  = 1'b0;
    if (cs_s || !en_i) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      idx_d   = '0;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            idx_d = '0;
            case (shreg)
              8'h02: begin
                state_d = ST_WRITE;
                clr_ovr = 1'b1;
              end
              8'h05:   state_d = ST_STATUS;
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_WRITE: begin
          if (byte_done) begin
            acc_d = shifted[WORD_W-1:0];
            if (idx == LAST_BYTE) begin
              idx_d    = '0;
              push_req = 1'b1;
            end else begin
              idx_d = idx + BW'(1);
            end
          end
        end
        ST_STATUS: begin
          // A fall with the bit count at 0 starts a byte, so the status is re-captured there.
          if (sclk_fall) begin
            if (bit_cnt == 3'd0) begin
              miso_d  = status[7];
              st_sh_d = {status[6:0], 1'b0};
            end else begin
              miso_d  = st_sh[7];
              st_sh_d = {st_sh[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.miso_o    = miso_q;
  assign bus.miso_en_o = (state == ST_STATUS);

  assign fifo_full        = (count == 2'd2);
  assign bus.word_valid_o = (count != 2'd0);
  assign bus.word_o       = mem[rd_ptr];
  assign do_pop           = bus.word_valid_o & bus.word_ready_i;
  assign do_push          = push_req & (~fifo_full | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shifted[WORD_W-1:0];
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (clr_ovr) overrun_o <= 1'b0;
      else if (push_req && !do_push) overrun_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_heichips25_spi_cfg_responder.sv
// Directed bench for heichips25_spi_cfg_responder: write, overrun, status, abort, unknown command, reset.
module tb_heichips25_spi_cfg_responder;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SYNC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic busy = 1'b0;
  logic configured = 1'b0;
  logic overrun, frame_active;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] q[$];
  logic [7:0]  rx, rx2;

  heichips25_spi_cfg_responder_if #(.WORD_W(WORD_W)) bus ();

  heichips25_spi_cfg_responder #(.WORD_W(WORD_W), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .busy_i(busy), .configured_i(configured),
    .bus(bus), .overrun_o(overrun), .frame_active_o(frame_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.word_valid_o && bus.word_ready_i) q.push_back(bus.word_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    bus.mosi_i = b;
    tick(4);
    r = bus.miso_o;
    bus.sclk_i = 1'b1;
    tick(4);
    bus.sclk_i = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], r[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [7:0] d;
    for (int b = 3; b >= 0; b--) spi_byte(w[b*8 +: 8], d);
  endtask

  task automatic frame_start();
    bus.cs_n_i = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    tick(4);
    bus.cs_n_i = 1'b1;
    tick(8);
  endtask

  initial begin
    logic r;
    bus.sclk_i = 1'b0; bus.cs_n_i = 1'b1; bus.mosi_i = 1'b0; bus.word_ready_i = 1'b1;
    tick(3);
    check("rst_miso", bus.miso_o, 0);
    check("rst_miso_en", bus.miso_en_o, 0);
    check("rst_valid", bus.word_valid_o, 0);
    check("rst_word", bus.word_o, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_active", frame_active, 0);
    rst = 1'b0;
    tick(3);

    // single word with exact latency
    frame_start();
    check("frame_active", frame_active, 1);
    spi_byte(8'h02, rx); spi_byte(8'hDE, rx); spi_byte(8'hAD, rx); spi_byte(8'hBE, rx);
    for (int i = 7; i >= 1; i--) spi_bit(1'(8'hEF >> i), r);
    bus.mosi_i = 1'b1;
    tick(4);
    bus.sclk_i = 1'b1;
    tick(SYNC + 1);
    check("lat_valid_early", bus.word_valid_o, 0);
    tick(1);
    check("lat_valid", bus.word_valid_o, 1);
    check("lat_word", bus.word_o, 32'hDEADBEEF);
    tick(1);
    check("valid_one_cycle", bus.word_valid_o, 0);
    tick(2);
    bus.sclk_i = 1'b0;
    check("write_miso_en", bus.miso_en_o, 0);
    frame_end();
    check("q1_size", q.size(), 1);
    check("q1_word", q[0], 32'hDEADBEEF);
    check("q1_overrun", overrun, 0);

    // overflow with sink stalled
    q.delete();
    bus.word_ready_i = 1'b0;
    frame_start();
    spi_byte(8'h02, rx);
    send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
    frame_end();
    check("ovr_overrun", overrun, 1);
    check("ovr_valid", bus.word_valid_o, 1);
    check("ovr_head_hold", bus.word_o, 32'h11111111);

    // status read while full and overrun
    busy = 1'b1; configured = 1'b0;
    frame_start();
    spi_byte(8'h05, rx);
    check("st_miso_en", bus.miso_en_o, 1);
    spi_byte(8'h00, rx);
    check("st_byte0", rx, 8'hB0);
    spi_byte(8'h00, rx2);
    check("st_byte1", rx2, 8'hB0);
    check("st_miso_en_held", bus.miso_en_o, 1);
    frame_end();
    check("st_miso_en_off", bus.miso_en_o, 0);
    check("st_miso_off", bus.miso_o, 0);
    busy = 1'b0;

    bus.word_ready_i = 1'b1;
    tick(4);
    check("drain_size", q.size(), 2);
    check("drain_w0", q[0], 32'h11111111);
    check("drain_w1", q[1], 32'h22222222);
    check("drain_valid", bus.word_valid_o, 0);

    // abort discards partial word
    q.delete();
    frame_start();
    spi_byte(8'h02, rx); spi_byte(8'hAA, rx); spi_byte(8'hBB, rx);
    frame_end();
    frame_start();
    spi_byte(8'h02, rx);
    send_word(32'h11223344);
    frame_end();
    check("abort_size", q.size(), 1);
    check("abort_word", q[0], 32'h11223344);
    check("abort_overrun_clr", overrun, 0);

    // unknown command
    q.delete();
    frame_start();
    spi_byte(8'h9F, rx);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'h02, rx);
      check("unk_miso_en", bus.miso_en_o, 0);
    end
    frame_end();
    check("unk_no_words", q.size(), 0);
    check("unk_frame_inactive", frame_active, 0);

    // reset in the middle of a write frame with a word queued
    bus.word_ready_i = 1'b0;
    frame_start();
    spi_byte(8'h02, rx);
    send_word(32'h5A5A5A5A);
    spi_byte(8'hAA, rx); spi_byte(8'hBB, rx);
    check("pre_rst_valid", bus.word_valid_o, 1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_valid", bus.word_valid_o, 0);
    check("mid_rst_word", bus.word_o, 0);
    check("mid_rst_miso_en", bus.miso_en_o, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_frame_active", frame_active, 0);
    bus.cs_n_i = 1'b1;
    tick(2);
    rst = 1'b0;
    q.delete();
    bus.word_ready_i = 1'b1;
    tick(4);
    frame_start();
    spi_byte(8'h02, rx);
    send_word(32'hCAFEF00D);
    frame_end();
    check("post_rst_size", q.size(), 1);
    check("post_rst_word", q[0], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
